// File: rtl/framebuffer_write_arbiter.sv
// Request/grant arbiter for the framebuffer BRAM write port: one owner at a time,
// its write bundle forwarded through one register stage, burst-limited preemption.
module framebuffer_write_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int MAX_BURST       = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  mode_rr,
  input  logic [NUM_CH-1:0]                     ch_req,
  output logic [NUM_CH-1:0]                     ch_grant,
  input  logic [NUM_CH-1:0]                     ch_fbuf_en_wr,
  input  logic [NUM_CH-1:0]                     ch_fbuf_wrea,
  input  logic [NUM_CH*FBUF_ADDR_WIDTH-1:0]     ch_fbuf_addr,
  input  logic [NUM_CH*FBUF_DATA_WIDTH-1:0]     ch_fbuf_data,
  input  logic [NUM_CH-1:0]                     ch_fbuf_rst_req_n,
  output logic                                  fbuf_en_wr,
  output logic                                  fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]            fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]            fbuf_data,
  output logic                                  fbuf_rst_req_n,
  output logic                                  busy,
  output logic [$clog2(NUM_CH)-1:0]             owner
);

  localparam int OW = $clog2(NUM_CH);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [OW:0]   CH_LIM    = (OW+1)'(NUM_CH);
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

  state_t          state_reg;
  logic [OW-1:0]   rr_ptr_reg;
  logic [CW-1:0]   burst_cnt_reg;

  logic [FBUF_ADDR_WIDTH-1:0] addr_arr [NUM_CH];
  logic [FBUF_DATA_WIDTH-1:0] data_arr [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi] = ch_fbuf_addr[gi*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
      assign data_arr[gi] = ch_fbuf_data[gi*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
    end
  endgenerate

  // Round-robin rotates the request vector so the pointer lands at bit 0,
  // then both modes reduce to a lowest-set-bit search plus an offset.
  logic [2*NUM_CH-1:0] req_rot2;
  logic [NUM_CH-1:0]   pick_vec;
  logic [OW-1:0]       win_off;
  logic [OW:0]         win_sum;
  logic [OW-1:0]       win_idx;
  logic [OW-1:0]       ptr_next;
  logic                win_valid;

  always_comb begin
    req_rot2  = {ch_req, ch_req} >> rr_ptr_reg;
    pick_vec  = mode_rr ? req_rot2[NUM_CH-1:0] : ch_req;
    win_off   = '0;
    win_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_off   = OW'(i);
        win_valid = 1'b1;
      end
    end
    win_sum = mode_rr ? ({1'b0, rr_ptr_reg} + {1'b0, win_off}) : {1'b0, win_off};
    if (win_sum >= CH_LIM) begin
      win_sum = win_sum - CH_LIM;
    end
    win_idx  = win_sum[OW-1:0];
    ptr_next = (win_idx == OW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
  end

  logic          own_beat;
  logic [CW-1:0] burst_cnt_next;
  logic          others_req;
  logic          release_own;

  always_comb begin
    own_beat       = ch_fbuf_en_wr[owner] & ch_fbuf_wrea[owner];
    burst_cnt_next = burst_cnt_reg;
    if (own_beat && burst_cnt_reg != BURST_LIM) begin
      burst_cnt_next = burst_cnt_reg + 1'b1;
    end
    others_req  = |(ch_req & ~ch_grant);
    release_own = !ch_req[owner] || (burst_cnt_next == BURST_LIM && others_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      burst_cnt_reg  <= '0;
      ch_grant       <= '0;
      busy           <= 1'b0;
      owner          <= '0;
      fbuf_en_wr     <= 1'b0;
      fbuf_wrea      <= 1'b0;
      fbuf_addr      <= '0;
      fbuf_data      <= '0;
      fbuf_rst_req_n <= 1'b1;
    end else begin
      case (state_reg)
        OWNED: begin
          fbuf_en_wr     <= ch_fbuf_en_wr[owner];
          fbuf_wrea      <= ch_fbuf_wrea[owner];
          fbuf_addr      <= addr_arr[owner];
          fbuf_data      <= data_arr[owner];
          fbuf_rst_req_n <= ch_fbuf_rst_req_n[owner];
          burst_cnt_reg  <= burst_cnt_next;
          if (release_own) begin
            state_reg <= GAP;
            ch_grant  <= '0;
            busy      <= 1'b0;
          end
        end
        default: begin
          // IDLE and GAP both arbitrate, so grants are separated by one GAP cycle.
          fbuf_en_wr     <= 1'b0;
          fbuf_wrea      <= 1'b0;
          fbuf_rst_req_n <= 1'b1;
          if (win_valid) begin
            state_reg     <= OWNED;
            ch_grant      <= NUM_CH'(1) << win_idx;
            owner         <= win_idx;
            busy          <= 1'b1;
            burst_cnt_reg <= '0;
            rr_ptr_reg    <= ptr_next;
          end else begin
            state_reg <= IDLE;
            ch_grant  <= '0;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Bench for framebuffer_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural ownership model.
module tb_framebuffer_write_arbiter;

  localparam int N    = 4;
  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode_rr;
  logic [N-1:0]     ch_req;
  logic [N-1:0]     ch_grant;
  logic [N-1:0]     ch_en;
  logic [N-1:0]     ch_wrea;
  logic [N*AW-1:0]  ch_addr;
  logic [N*DW-1:0]  ch_data;
  logic [N-1:0]     ch_rstn;
  logic             fbuf_en_wr;
  logic             fbuf_wrea;
  logic [AW-1:0]    fbuf_addr;
  logic [DW-1:0]    fbuf_data;
  logic             fbuf_rst_req_n;
  logic             busy;
  logic [1:0]       owner;

  int checks   = 0;
  int failures = 0;

  framebuffer_write_arbiter #(
    .NUM_CH(N), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .mode_rr(mode_rr), .ch_req(ch_req), .ch_grant(ch_grant),
    .ch_fbuf_en_wr(ch_en), .ch_fbuf_wrea(ch_wrea), .ch_fbuf_addr(ch_addr),
    .ch_fbuf_data(ch_data), .ch_fbuf_rst_req_n(ch_rstn),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr),
    .fbuf_data(fbuf_data), .fbuf_rst_req_n(fbuf_rst_req_n), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the port, whether a gap is pending, burst count, pointer.
  int         m_owner;   // -1: nobody
  bit         m_gap;
  int         m_beats;
  int         m_ptr;
  logic [N-1:0]  e_grant;
  logic          e_busy;
  logic [1:0]    e_owner;
  logic          e_en, e_wrea, e_rstn;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_owner = -1; m_gap = 1'b0; m_beats = 0; m_ptr = 0;
    e_grant = '0; e_busy = 1'b0; e_owner = '0;
    e_en = 1'b0; e_wrea = 1'b0; e_rstn = 1'b1; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      int  o = m_owner;
      bit  waiting = 1'b0;
      e_en   = ch_en[o];
      e_wrea = ch_wrea[o];
      e_addr = ch_addr[o*AW +: AW];
      e_data = ch_data[o*DW +: DW];
      e_rstn = ch_rstn[o];
      if (ch_en[o] && ch_wrea[o] && m_beats < MAXB) m_beats++;
      for (int k = 0; k < N; k++) if (k != o && ch_req[k]) waiting = 1'b1;
      if (!ch_req[o] || (m_beats == MAXB && waiting)) begin
        m_owner = -1; m_gap = 1'b1; e_grant = '0; e_busy = 1'b0;
      end
    end else begin
      int w = -1;
      if (m_gap) begin e_en = 1'b0; e_wrea = 1'b0; e_rstn = 1'b1; end
      m_gap = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c = mode_rr ? (m_ptr + k) % N : k;
        if (w < 0 && ch_req[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w; m_beats = 0; m_ptr = (w + 1) % N;
        e_grant = N'(1 << w); e_owner = 2'(w); e_busy = 1'b1;
      end else begin
        e_grant = '0; e_busy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_req = '0; ch_en = '0; ch_wrea = '0; ch_rstn = '1; ch_addr = '0; ch_data = '0;
  endtask

  task automatic set_ch(input int i, input logic en, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rn);
    ch_en[i] = en; ch_wrea[i] = wr; ch_rstn[i] = rn;
    ch_addr[i*AW +: AW] = a; ch_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    mode_rr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_rr = 1'b0; clear_inputs();
    #3;
    checks++;
    if (ch_grant !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctrl grant=%b busy=%b owner=%0d required 0000/0/0", ch_grant, busy, owner);
    end
    checks++;
    if ({fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n} !== 3'b001 || fbuf_addr !== '0 || fbuf_data !== '0) begin
      failures++;
      $display("FAIL reset_fbuf en=%b wrea=%b rstn=%b addr=%h data=%h required 0/0/1/0/0",
               fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n, fbuf_addr, fbuf_data);
    end
    @(posedge clk); #1; rst = 1'b0; model_reset();
    tick();
    checks++;
    if (ch_grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req grant=%b busy=%b required 0000/0", ch_grant, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_grant_forward();
    do_reset();
    ch_req = 4'b0100;
    tick();
    checks++;
    if (ch_grant !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_grant grant=%b owner=%0d busy=%b required 0100/2/1", ch_grant, owner, busy);
    end
    set_ch(2, 1'b1, 1'b1, 19'h00123, 8'hA5, 1'b1);
    set_ch(0, 1'b1, 1'b1, 19'h7FFFF, 8'h11, 1'b0);
    tick();
    checks++;
    if (fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1 || fbuf_addr !== 19'h00123 ||
        fbuf_data !== 8'hA5 || fbuf_rst_req_n !== 1'b1) begin
      failures++;
      $display("FAIL forward en=%b wrea=%b addr=%h data=%h rstn=%b required 1/1/00123/a5/1",
               fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, fbuf_rst_req_n);
    end
    clear_inputs();
    tick();
    tick();
    $display("test_grant_forward done");
  endtask

  task automatic test_rr_order();
    int order[4] = '{0, 1, 3, 0};
    do_reset();
    mode_rr = 1'b1;
    ch_req  = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      int c = order[s];
      tick();
      checks++;
      if (ch_grant !== N'(1 << c) || owner !== 2'(c)) begin
        failures++;
        $display("FAIL rr_grant step=%0d grant=%b owner=%0d required ch%0d", s, ch_grant, owner, c);
      end
      for (int b = 0; b < 3; b++) begin
        set_ch(c, 1'b1, 1'b1, 19'(s*16 + b), 8'(s*16 + b), 1'b1);
        tick();
      end
      checks++;
      if (ch_grant !== N'(1 << c) || fbuf_addr !== 19'(s*16 + 2) || fbuf_en_wr !== 1'b1) begin
        failures++;
        $display("FAIL rr_burst step=%0d grant=%b addr=%h en=%b required ch%0d/%h/1",
                 s, ch_grant, fbuf_addr, fbuf_en_wr, c, 19'(s*16 + 2));
      end
      set_ch(c, 1'b0, 1'b0, '0, '0, 1'b1);
      ch_req[c] = 1'b0;
      tick();
      checks++;
      if (ch_grant !== '0 || busy !== 1'b0 || fbuf_en_wr !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap step=%0d grant=%b busy=%b en=%b required 0000/0/0",
                 s, ch_grant, busy, fbuf_en_wr);
      end
      ch_req[c] = 1'b1;
    end
    $display("test_rr_order done");
  endtask

  task automatic test_burst_limit();
    do_reset();
    mode_rr = 1'b1;
    ch_req  = 4'b0010;
    tick();
    ch_req = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      set_ch(1, 1'b1, 1'b1, 19'(b), 8'(b), 1'b1);
      tick();
      checks++;
      if (ch_grant !== ((b < 3) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL preempt beat=%0d grant=%b required %b", b + 1, ch_grant,
                 (b < 3) ? 4'b0010 : 4'b0000);
      end
    end
    set_ch(1, 1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    checks++;
    if (ch_grant !== 4'b0100 || owner !== 2'd2) begin
      failures++;
      $display("FAIL preempt_next grant=%b owner=%0d required 0100/2", ch_grant, owner);
    end
    do_reset();
    mode_rr = 1'b1;
    ch_req  = 4'b0010;
    tick();
    for (int b = 0; b < 10; b++) begin
      set_ch(1, 1'b1, 1'b1, 19'(100 + b), 8'(b), 1'b1);
      tick();
    end
    checks++;
    if (ch_grant !== 4'b0010 || busy !== 1'b1 || fbuf_addr !== 19'd109) begin
      failures++;
      $display("FAIL keep_alone grant=%b busy=%b addr=%0d required 0010/1/109", ch_grant, busy, fbuf_addr);
    end
    $display("test_burst_limit done");
  endtask

  task automatic test_rst_req_mask();
    do_reset();
    mode_rr = 1'b0;
    set_ch(1, 1'b0, 1'b0, '0, '0, 1'b0);
    ch_req = 4'b0011;
    tick();
    tick();
    tick();
    checks++;
    if (ch_grant !== 4'b0001 || fbuf_rst_req_n !== 1'b1) begin
      failures++;
      $display("FAIL clear_masked grant=%b rstn=%b required 0001/1", ch_grant, fbuf_rst_req_n);
    end
    ch_req = 4'b0010;
    tick();
    tick();
    checks++;
    if (ch_grant !== 4'b0010 || fbuf_rst_req_n !== 1'b1) begin
      failures++;
      $display("FAIL clear_grant grant=%b rstn=%b required 0010/1", ch_grant, fbuf_rst_req_n);
    end
    tick();
    checks++;
    if (fbuf_rst_req_n !== 1'b0) begin
      failures++;
      $display("FAIL clear_forward rstn=%b required 0", fbuf_rst_req_n);
    end
    $display("test_rst_req_mask done");
  endtask

  task automatic test_async_reset();
    do_reset();
    mode_rr = 1'b0;
    ch_req  = 4'b0100;
    tick();
    set_ch(2, 1'b1, 1'b1, 19'h4567, 8'h3C, 1'b0);
    tick();
    checks++;
    if (fbuf_en_wr !== 1'b1 || owner !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset en=%b owner=%0d required 1/2", fbuf_en_wr, owner);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ch_grant !== '0 || busy !== 1'b0 || owner !== 2'd0 || fbuf_en_wr !== 1'b0 ||
        fbuf_wrea !== 1'b0 || fbuf_addr !== '0 || fbuf_data !== '0 || fbuf_rst_req_n !== 1'b1) begin
      failures++;
      $display("FAIL async_reset grant=%b busy=%b owner=%0d en=%b wrea=%b addr=%h data=%h rstn=%b required all reset values",
               ch_grant, busy, owner, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, fbuf_rst_req_n);
    end
    clear_inputs();
    model_reset();
    #1;
    rst = 1'b0;
    mode_rr = 1'b1;
    ch_req  = 4'b1010;
    tick();
    checks++;
    if (ch_grant !== 4'b0010 || owner !== 2'd1) begin
      failures++;
      $display("FAIL ptr_restart grant=%b owner=%0d required 0010/1", ch_grant, owner);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_mode_change();
    do_reset();
    mode_rr = 1'b1;
    ch_req  = 4'b1000;
    tick();
    mode_rr = 1'b0;
    ch_req  = 4'b1001;
    tick();
    tick();
    tick();
    checks++;
    if (ch_grant !== 4'b1000 || owner !== 2'd3) begin
      failures++;
      $display("FAIL mode_hold grant=%b owner=%0d required 1000/3", ch_grant, owner);
    end
    ch_req = 4'b0001;
    tick();
    ch_req = 4'b1001;
    tick();
    checks++;
    if (ch_grant !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL mode_next grant=%b owner=%0d required 0001/0", ch_grant, owner);
    end
    $display("test_mode_change done");
  endtask

  task automatic test_random();
    do_reset();
    mode_rr = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) ch_req[i] = ~ch_req[i];
        set_ch(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               19'($urandom), 8'($urandom), 1'($urandom_range(0, 4) != 0));
      end
      if ($urandom_range(0, 19) == 0) mode_rr = ~mode_rr;
      tick();
      checks++;
      if ({ch_grant, busy, owner, fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n, fbuf_addr, fbuf_data} !==
          {e_grant, e_busy, e_owner, e_en, e_wrea, e_rstn, e_addr, e_data}) begin
        failures++;
        $display("FAIL random cyc=%0d grant=%b busy=%b owner=%0d en=%b wrea=%b rstn=%b addr=%h data=%h required grant=%b busy=%b owner=%0d en=%b wrea=%b rstn=%b addr=%h data=%h",
                 cyc, ch_grant, busy, owner, fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n, fbuf_addr, fbuf_data,
                 e_grant, e_busy, e_owner, e_en, e_wrea, e_rstn, e_addr, e_data);
      end
      checks++;
      if ($countones(ch_grant) > 1) begin
        failures++;
        $display("FAIL onehot cyc=%0d grant=%b required at most one bit", cyc, ch_grant);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached required finish before 500000");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_grant_forward();
    test_rr_order();
    test_burst_limit();
    test_rst_req_mask();
    test_async_reset();
    test_mode_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_write_arbiter.md
Name: framebuffer_write_arbiter

Overview:
N-channel write arbiter in front of the framebuffer BRAM write port. It replaces static select-line muxing with request/grant ownership. Each producer requests the port, receives a one-hot grant, and has its write bundle forwarded through a registered output stage. Arbitration is round-robin or fixed-priority, and a burst limit preempts an owner when other channels are waiting.

Parameters:
NUM_CH, 4, number of producer channels (2..16)
FBUF_ADDR_WIDTH, 19, framebuffer address width
FBUF_DATA_WIDTH, 8, framebuffer data width
MAX_BURST, 64, write beats an owner may issue before it can be preempted (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode_rr  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
ch_req  in  NUM_CH  per-channel ownership request
ch_grant  out  NUM_CH  one-hot grant, registered
ch_fbuf_en_wr  in  NUM_CH  per-channel BRAM enable
ch_fbuf_wrea  in  NUM_CH  per-channel write strobe
ch_fbuf_addr  in  NUM_CH*FBUF_ADDR_WIDTH  packed addresses, channel i at [i*W +: W]
ch_fbuf_data  in  NUM_CH*FBUF_DATA_WIDTH  packed data, same packing
ch_fbuf_rst_req_n  in  NUM_CH  per-channel clear request, active low
fbuf_en_wr  out  1  BRAM enable
fbuf_wrea  out  1  BRAM write strobe
fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
fbuf_data  out  FBUF_DATA_WIDTH  BRAM data
fbuf_rst_req_n  out  1  clear request to framebuffer, active low
busy  out  1  a channel currently owns the port
owner  out  $clog2(NUM_CH)  index of the current or last owner

Behaviour:
- Reset (async, immediate) values:
  - ch_grant=0, busy=0, owner=0.
  - fbuf_en_wr=0, fbuf_wrea=0, fbuf_addr=0, fbuf_data=0, fbuf_rst_req_n=1.
  - State=IDLE, burst_cnt=0, round-robin pointer=0.
- FSM states:
  - IDLE: if any ch_req is set, pick a winner. Next cycle: OWNED, ch_grant=onehot(winner), owner=winner, busy=1, burst_cnt=0. If no request, stay in IDLE.
  - OWNED: every cycle, register the owner's en_wr, wrea, addr, data and rst_req_n onto the fbuf_* outputs. Forwarding latency is exactly 1 cycle.
    - A beat is a cycle with the owner's en_wr & wrea both high. Each beat increments burst_cnt, which saturates at MAX_BURST.
  - Release from OWNED when the owner's ch_req=0, or when burst_cnt==MAX_BURST and any other channel requests. Next state is GAP.
  - GAP: exactly one cycle.
    - ch_grant=0, busy=0.
    - fbuf_en_wr=0, fbuf_wrea=0, fbuf_rst_req_n=1.
    - fbuf_addr and fbuf_data hold their last values.
    - Then go to IDLE, which can arbitrate in that same cycle.
- Arbitration:
  - Fixed priority: the lowest requesting index wins.
  - Round-robin: search from pointer upward with wrap-around. On each grant, pointer := winner+1 mod NUM_CH.
  - mode_rr is sampled only at arbitration time. A change during OWNED has no effect until the next arbitration.
- Handshake rules:
  - A channel may write only after it sees its ch_grant bit set.
  - Signals from non-granted channels are ignored, including their rst_req_n.
  - A channel dropping ch_req releases the port. Its write signals in that same cycle are still forwarded.
  - If the owner holds ch_req and no other channel requests, it keeps ownership past MAX_BURST.
  - A preempted channel that still requests re-enters arbitration. Under round-robin it goes behind the other waiters.
- Boundaries:
  - All requests arriving simultaneously are resolved by the rules above. At most one grant bit is ever set.
  - While not OWNED, fbuf_en_wr and fbuf_wrea are never 1 at the outputs.
  - When NUM_CH is not a power of 2, the pointer wraps at NUM_CH-1 to 0.
  - Reset asserted mid-burst forces the reset values immediately. Any in-flight beat is dropped.

Test Plan:
1. Reset release, then ch_req=4'b0100 with mode_rr=0 -> ch_grant=4'b0100 one cycle later, owner=2, busy=1. ch2 write of addr 0x00123 / data 0xA5 appears on fbuf_* one cycle after it is presented.
2. ch_req=4'b1011 held, mode_rr=1, each owner drops ch_req after 3 beats -> grant order ch0, ch1, ch3, ch0. Exactly one GAP cycle separates grants, with fbuf_en_wr=0 in the GAP.
3. MAX_BURST=4; ch1 streams writes continuously while ch2 requests -> ch1 released after its 4th beat, GAP, then ch2 granted. With ch2 idle instead, ch1 keeps the port beyond 4 beats.
4. ch_req=4'b0011 in fixed mode, ch1 holding ch_fbuf_rst_req_n=0 while not granted -> fbuf_rst_req_n stays 1. Once ch1 is granted, fbuf_rst_req_n=0 one cycle later.
5. Assert rst mid-burst while fbuf_en_wr=1 -> all outputs take their reset values in the same cycle, without waiting for a clk edge. After release, arbitration restarts from pointer 0.
6. mode_rr toggled 1→0 while ch3 owns the port -> ch3 keeps the grant. At the next arbitration with ch_req=4'b1001, ch0 wins.
